djb2_hash_sched: RTL and testbench

- Shared djb2 hash engine with round-robin arbitration among NREQ requesters.
- Each requester submits one 32-bit word plus a byte count.
- The block sequences the bytes through the djb2 step, one byte per clock: hash = hash*33 + byte, seeded with 5381.
- It returns the 32-bit hash tagged with the requester id. It sits between client logic and the hashing datapath, so one engine serves several lookup clients.

---
 rtl/djb2_hash_sched.sv | 190 +++++++++++++++++++
 tb/tb_djb2_hash_sched.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/djb2_hash_sched.sv
`default_nettype none
// ============================================================================
//  Module   : djb2_hash_sched
//  Purpose  : Shared djb2 hash engine. NREQ requesters are served in
//             round-robin order. Each job is one 32-bit word plus a byte
//             count (0..4; 5..7 are treated as 4). The bytes are folded one
//             per clock, starting from seed 5381, and the 32-bit result is
//             returned tagged with the id of the requester that owned the job.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             req_valid[i]    - requester i has a job
//             req_data        - 32 bits per requester, byte k at [8k+7:8k]
//             req_len         - 3 bits per requester, byte count
//             req_ready       - one-hot grant (IDLE only)
//             res_valid/ready - result handshake
//             res_hash        - final hash
//             res_id          - index of the requester that owned the job
//  Options  : define DJB2_XOR_EN for the djb2a step (hash*33 ^ byte)
//             instead of the default additive step (hash*33 + byte).
//  Revision : 1.0 - initial release
// ============================================================================
module djb2_hash_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_data,
  input  logic [3*NREQ-1:0]    req_len,
  output logic [NREQ-1:0]      req_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [31:0]          res_hash,
  output logic [IDW-1:0]       res_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HASH = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0]  C_SEED    = 32'd5381;
  localparam logic [IDW:0] C_NREQ_W  = (IDW+1)'(NREQ);

  state_t          state_q,  state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [31:0]     data_q,   data_d;
  logic [2:0]      len_q,    len_d;
  logic [IDW-1:0]  id_q,     id_d;
  logic [31:0]     hash_q,   hash_d;
  logic [2:0]      cnt_q,    cnt_d;

  // Arbitration signals
  logic [NREQ-1:0] rot_valid;
  logic [IDW-1:0]  win_off;
  logic [IDW:0]    win_sum;
  logic [IDW-1:0]  win_idx;
  logic [IDW:0]    nxt_sum;
  logic [IDW-1:0]  nxt_ptr;
  logic            any_valid;
  logic [31:0]     sel_data;
  logic [2:0]      sel_len;
  logic [2:0]      sel_len_clamped;

  // Datapath signals
  logic [7:0]      cur_byte;
  logic [31:0]     hash_x33;
  logic [31:0]     hash_step;

  // --------------------------------------------------------------------------
  // Round-robin winner: rotate the request vector so rr_ptr sits at bit 0,
  // find the lowest set bit, then rotate the offset back modulo NREQ.
  // --------------------------------------------------------------------------
  always_comb begin
    rot_valid = NREQ'({req_valid, req_valid} >> rr_ptr_q);
    any_valid = |req_valid;
    win_off   = '0;
    for (int j = NREQ-1; j >= 0; j--) begin
      if (rot_valid[j]) begin
        win_off = IDW'(j);
      end
    end
    win_sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
    win_idx = (win_sum >= C_NREQ_W) ? IDW'(win_sum - C_NREQ_W) : IDW'(win_sum);
    nxt_sum = {1'b0, win_idx} + {{IDW{1'b0}}, 1'b1};
    nxt_ptr = (nxt_sum == C_NREQ_W) ? '0 : IDW'(nxt_sum);
  end

  // Job fields of the winning requester
  always_comb begin
    sel_data = '0;
    sel_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) begin
        sel_data = req_data[32*i +: 32];
        sel_len  = req_len[3*i +: 3];
      end
    end
    sel_len_clamped = (sel_len > 3'd4) ? 3'd4 : sel_len;
  end

  // --------------------------------------------------------------------------
  // One djb2 step per clock; cnt never exceeds 3 while hashing.
  // --------------------------------------------------------------------------
  always_comb begin
    case (cnt_q[1:0])
      2'd0:    cur_byte = data_q[7:0];
      2'd1:    cur_byte = data_q[15:8];
      2'd2:    cur_byte = data_q[23:16];
      default: cur_byte = data_q[31:24];
    endcase
    hash_x33 = (hash_q << 5) + hash_q;
`ifdef DJB2_XOR_EN
    hash_step = hash_x33 ^ {24'b0, cur_byte};
`else
    hash_step = hash_x33 + {24'b0, cur_byte};
`endif
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    data_d    = data_q;
    len_d     = len_q;
    id_d      = id_q;
    hash_d    = hash_q;
    cnt_d     = cnt_q;
    req_ready = '0;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          req_ready = NREQ'(1) << win_idx;
          data_d    = sel_data;
          len_d     = sel_len_clamped;
          id_d      = win_idx;
          hash_d    = C_SEED;
          cnt_d     = '0;
          rr_ptr_d  = nxt_ptr;
          state_d   = (sel_len_clamped == 3'd0) ? DONE : HASH;
        end
      end
      HASH: begin
        hash_d = hash_step;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == len_q - 3'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      data_q   <= '0;
      len_q    <= '0;
      id_q     <= '0;
      hash_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      len_q    <= len_d;
      id_q     <= id_d;
      hash_q   <= hash_d;
      cnt_q    <= cnt_d;
    end
  end

  assign res_valid = (state_q == DONE);
  assign res_hash  = hash_q;
  assign res_id    = id_q;

endmodule
`default_nettype wire

// File: tb/tb_djb2_hash_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_djb2_hash_sched
//  Purpose  : Self-checking bench for djb2_hash_sched. A job-level model
//             (grant from a rotating pointer, whole-word djb2 fold, countdown
//             to the result) is compared with the DUT on every cycle, and
//             directed jobs pin literal hash values, latencies and grants.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_djb2_hash_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [32*NREQ-1:0]  req_data;
  logic [3*NREQ-1:0]   req_len;
  logic [NREQ-1:0]     req_ready;
  logic                res_valid;
  logic                res_ready;
  logic [31:0]         res_hash;
  logic [IDW-1:0]      res_id;

  int n_checks = 0;
  int n_pass   = 0;

  djb2_hash_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_len   (req_len),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_hash  (res_hash),
    .res_id    (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference djb2 over the first n bytes of a word
  function automatic logic [31:0] djb2(input logic [31:0] d, input int n);
    logic [31:0] h;
    logic [31:0] b;
    h = 32'd5381;
    for (int k = 0; k < n; k++) begin
      b = (d >> (8*k)) & 32'hFF;
`ifdef DJB2_XOR_EN
      h = (h * 32'd33) ^ b;
`else
      h = (h * 32'd33) + b;
`endif
    end
    return h;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int start);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  // --------------------------------------------------------------------------
  // Job-level model, checked every cycle once the first reset is seen
  // --------------------------------------------------------------------------
  bit          m_on   = 0;
  int          m_rr   = 0;
  bit          m_busy = 0;
  int          m_wait = 0;
  bit          m_done = 0;
  logic [31:0] m_hash = '0;
  int          m_id   = 0;

  always @(negedge clk) begin
    logic [NREQ-1:0] er;
    int w;
    int ln;
    logic [31:0] d;
    if (m_on) begin
      er = '0;
      w  = pick(req_valid, m_rr);
      if (!m_busy && !m_done && w >= 0) er[w] = 1'b1;
      check("model_req_ready", 32'(req_ready), 32'(er));
      check("model_res_valid", 32'(res_valid), 32'(m_done));
      if (m_done) begin
        check("model_res_hash", res_hash, m_hash);
        check("model_res_id", 32'(res_id), 32'(m_id));
      end
    end
    if (rst) begin
      m_on = 1; m_rr = 0; m_busy = 0; m_done = 0; m_wait = 0;
    end else if (m_on) begin
      if (m_done) begin
        if (res_ready) m_done = 0;
      end else if (m_busy) begin
        m_wait--;
        if (m_wait == 0) begin m_busy = 0; m_done = 1; end
      end else begin
        w = pick(req_valid, m_rr);
        if (w >= 0) begin
          d  = 32'(req_data >> (32*w));
          ln = int'(3'(req_len >> (3*w)));
          if (ln > 4) ln = 4;
          m_hash = djb2(d, ln);
          m_id   = w;
          m_rr   = (w + 1) % NREQ;
          if (ln == 0) m_done = 1;
          else begin m_busy = 1; m_wait = ln; end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed job: grant in the accept cycle, latency, literal hash and id,
  // optional hold with res_ready low while another requester waits.
  // --------------------------------------------------------------------------
  task automatic run_job(input int r, input logic [31:0] d, input int len,
                         input logic [31:0] exp_h, input int exp_lat,
                         input int hold, input string nm);
    int lat;
    logic [NREQ-1:0] one;
    one = '0;
    one[r] = 1'b1;
    req_valid = one;
    req_data[32*r +: 32] = d;
    req_len[3*r +: 3] = 3'(len);
    res_ready = (hold == 0);
    @(negedge clk);
    check({nm, "_grant"}, 32'(req_ready), 32'(one));
    tick();
    req_valid = '0;
    lat = 1;
    @(negedge clk);
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    check({nm, "_hash"}, res_hash, exp_h);
    check({nm, "_id"}, 32'(res_id), 32'(r));
    for (int h = 0; h < hold; h++) begin
      tick();
      req_valid = '0;
      req_valid[0] = 1'b1;
      @(negedge clk);
      check({nm, "_hold_valid"}, 32'(res_valid), 32'd1);
      check({nm, "_hold_hash"}, res_hash, exp_h);
      check({nm, "_hold_noready"}, 32'(req_ready), 32'd0);
    end
    tick();
    req_valid = '0;
    res_ready = 1'b1;
    tick();
  endtask

  initial begin
    int grants[5];
    int ids[5];
    int ng;
    int nr;
    int g;

    rst = 1'b1; req_valid = '0; req_data = '0; req_len = '0; res_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_res_hash", res_hash, 32'd0);
    check("reset_res_id", 32'(res_id), 32'd0);
    tick();

`ifdef DJB2_XOR_EN
    run_job(0, 32'h00000061, 1, 32'h0002B5C4, 2, 0, "job_a");
    run_job(1, 32'h00006261, 2, 32'h00596E26, 3, 5, "job_b");
`else
    run_job(0, 32'h00000061, 1, 32'h0002B606, 2, 0, "job_a");
    run_job(1, 32'h00006261, 2, 32'h00597728, 3, 5, "job_b");
`endif
    run_job(2, 32'hDEADBEEF, 0, 32'h00001505, 1, 0, "job_len0");
    run_job(3, 32'h44332211, 7, djb2(32'h44332211, 4), 5, 0, "job_clamp");

    // All requesters continuously valid: rotation starting from 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_data[32*i +: 32] = $urandom;
      req_len[3*i +: 3] = 3'd1;
    end
    res_ready = 1'b1;
    req_valid = '1;
    ng = 0; nr = 0;
    for (int k = 0; k < 5; k++) begin grants[k] = -1; ids[k] = -1; end
    for (int c = 0; c < 60 && (ng < 5 || nr < 5); c++) begin
      @(negedge clk);
      if (req_ready != '0 && ng < 5) begin
        g = -1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
        grants[ng] = g;
        ng++;
      end
      if (res_valid && nr < 5) begin
        ids[nr] = int'(res_id);
        nr++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr_grant_%0d", k), 32'(grants[k]), 32'(k % NREQ));
      check($sformatf("rr_id_%0d", k), 32'(ids[k]), 32'(k % NREQ));
    end
    tick();
    req_valid = '0;
    repeat (6) tick();

    // Reset in the middle of a len=4 job
    req_valid = '0;
    req_valid[1] = 1'b1;
    req_len[3 +: 3] = 3'd4;
    req_len[0 +: 3] = 3'd1;
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("abort_no_res_valid", 32'(res_valid), 32'd0);
      tick();
    end
    req_valid = 4'b1001;
    @(negedge clk);
    check("abort_rr_reset_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    repeat (5) tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = ($urandom_range(0, 2) != 0);
        req_data[32*i +: 32] = $urandom;
        req_len[3*i +: 3] = 3'($urandom_range(0, 7));
      end
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
